// File: rtl/ha_flow_pkg.sv
// Shared definitions for the HA token-flow blocks: default widths, the
// arbiter state encoding and a constant-evaluable clog2 helper.
package ha_flow_pkg;

  // Default token data width, matching the HA_*W DataIn_1_BW/DataOut_1_BW widths.
  localparam int DATA_BW_DEF = 32;

  // Arbiter states: IDLE picks a new winner every beat, LOCK holds a multi-beat packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arbState_t;

  // Ceiling log2, usable in parameter defaults. Returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ha_rr_picker.sv
// Combinational round-robin picker: starting at rrPtr and wrapping modulo
// NUM_REQ, selects the first asserted request and reports it as a one-hot
// grant and as an index. Shared by the token arbiter and later schedulers.
module ha_rr_picker
  import ha_flow_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_BW  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [TAG_BW-1:0]  rrPtr,
  output logic               anyReq,
  output logic [NUM_REQ-1:0] grantOnehot,
  output logic [TAG_BW-1:0]  grantIdx
);

  // Scan rrPtr, rrPtr+1, ... and keep only the first asserted request.
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    cand        = 0;
    anyReq      = 1'b0;
    grantOnehot = '0;
    grantIdx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rrPtr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!anyReq && reqVec[cand]) begin
        anyReq            = 1'b1;
        grantOnehot[cand] = 1'b1;
        grantIdx          = TAG_BW'(cand);
      end
    end
  end

endmodule

// File: rtl/ha_token_arbiter.sv
// Shares one HA_TW token stage between NUM_REQ HA_INW input streams.
// Round-robin between streams, packet lock until the last beat, and a single
// output register per beat carrying data, last flag and source tag.
module ha_token_arbiter
  import ha_flow_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_BW = DATA_BW_DEF,
  parameter int TAG_BW  = clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*DATA_BW-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tok_valid,
  output logic [DATA_BW-1:0]         tok_data,
  output logic [TAG_BW-1:0]          tok_tag,
  output logic                       tok_last,
  input  logic                       tok_ready,
  output logic [TAG_BW-1:0]          cur_grant,
  output logic                       locked,
  output logic [15:0]                pkt_cnt
);

  arbState_t          state;
  logic [TAG_BW-1:0]  rrPtr;
  logic               loadEn;
  logic               pickAny;
  logic [NUM_REQ-1:0] pickOnehot;
  logic [TAG_BW-1:0]  pickIdx;
  logic [TAG_BW-1:0]  selIdx;
  logic               accept;
  logic               selLast;
  logic [DATA_BW-1:0] selData;

  // Wrap-around successor of a requester index.
  function automatic logic [TAG_BW-1:0] nextIdx(input logic [TAG_BW-1:0] idx);
    return (idx == TAG_BW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  ha_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .TAG_BW  (TAG_BW)
  ) u_picker (
    .reqVec      (req_valid),
    .rrPtr       (rrPtr),
    .anyReq      (pickAny),
    .grantOnehot (pickOnehot),
    .grantIdx    (pickIdx)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign loadEn = !tok_valid || tok_ready;
  assign locked = (state == LOCK);

  // Choose the source of this cycle's beat and drive the per-requester accepts.
  // While reset is held no requester may see an accept, so req_ready is gated.
  always_comb begin
    req_ready = '0;
    selIdx    = (state == LOCK) ? cur_grant : pickIdx;
    accept    = 1'b0;
    if (rst && loadEn) begin
      if (state == IDLE) begin
        req_ready = pickOnehot;
        accept    = pickAny;
      end else begin
        req_ready[cur_grant] = 1'b1;
        accept               = req_valid[cur_grant];
      end
    end
    selLast = req_last[selIdx];
    selData = req_data[int'(selIdx)*DATA_BW +: DATA_BW];
  end

  // FSM, round-robin pointer, output register and packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rrPtr     <= '0;
      cur_grant <= '0;
      tok_valid <= 1'b0;
      tok_data  <= '0;
      tok_tag   <= '0;
      tok_last  <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order in this block.
      if (accept) begin
        tok_valid <= 1'b1;
        tok_data  <= selData;
        tok_tag   <= selIdx;
        tok_last  <= selLast;
      end else if (tok_ready) begin
        tok_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (selLast) begin
              rrPtr   <= nextIdx(selIdx);
              pkt_cnt <= pkt_cnt + 16'd1;
            end else begin
              state     <= LOCK;
              cur_grant <= selIdx;
            end
          end
        end
        LOCK: begin
          if (accept && selLast) begin
            state   <= IDLE;
            rrPtr   <= nextIdx(cur_grant);
            pkt_cnt <= pkt_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_token_arbiter.sv
// Directed bench for ha_token_arbiter: reset, round robin, packet lock,
// backpressure, pointer wrap with counter rollover, reset inside a packet.
module tb_ha_token_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_BW = 32;
  localparam int TAG_BW  = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ*DATA_BW-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       tok_valid;
  logic [DATA_BW-1:0]         tok_data;
  logic [TAG_BW-1:0]          tok_tag;
  logic                       tok_last;
  logic                       tok_ready;
  logic [TAG_BW-1:0]          cur_grant;
  logic                       locked;
  logic [15:0]                pkt_cnt;

  int checks = 0;
  int errors = 0;

  ha_token_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_BW (DATA_BW),
    .TAG_BW  (TAG_BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tok_valid (tok_valid),
    .tok_data  (tok_data),
    .tok_tag   (tok_tag),
    .tok_last  (tok_last),
    .tok_ready (tok_ready),
    .cur_grant (cur_grant),
    .locked    (locked),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic setData(input int idx, input logic [DATA_BW-1:0] value);
    req_data[idx*DATA_BW +: DATA_BW] = value;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkBeat(input string name, input logic [TAG_BW-1:0] expTag,
                           input logic [DATA_BW-1:0] expData, input logic expLast);
    checks++;
    if ({tok_valid, tok_tag, tok_data, tok_last} !== {1'b1, expTag, expData, expLast}) begin
      errors++;
      $display("FAIL %s: got valid=%b tag=%0d data=%h last=%b, expected valid=1 tag=%0d data=%h last=%b",
               name, tok_valid, tok_tag, tok_data, tok_last, expTag, expData, expLast);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    tok_ready = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) setData(i, 32'hA0 + i);
    #12;
    checks++;
    if ({req_ready, tok_valid, pkt_cnt, locked} !== {4'b0000, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b tok_valid=%b pkt_cnt=%h locked=%b, expected 0000 0 0000 0",
               req_ready, tok_valid, pkt_cnt, locked);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got ready=%b expected 0001", req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [TAG_BW-1:0] expTag;
    for (int k = 0; k < 5; k++) begin
      step();
      expTag = TAG_BW'(k % NUM_REQ);
      checkBeat("rr_beat", expTag, 32'hA0 + 32'(expTag), 1'b1);
    end
    checks++;
    if (pkt_cnt !== 16'd5) begin
      errors++;
      $display("FAIL rr_pkt_cnt: got %0d expected 5", pkt_cnt);
    end
    req_valid = '0;
    step();
    checks++;
    if (tok_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: got tok_valid=%b expected 0", tok_valid);
    end
  endtask

  task automatic test_lock();
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    setData(1, 32'hB100_0000);
    setData(2, 32'hC200_0000);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL lock_first_ready: got %b expected 0010", req_ready);
    end
    step();
    checkBeat("lock_beat0", 2'd1, 32'hB100_0000, 1'b0);
    checks++;
    if ({locked, cur_grant, req_ready} !== {1'b1, 2'd1, 4'b0010}) begin
      errors++;
      $display("FAIL lock_state0: got locked=%b grant=%0d ready=%b expected 1 1 0010",
               locked, cur_grant, req_ready);
    end
    setData(1, 32'hB100_0001);
    step();
    checkBeat("lock_beat1", 2'd1, 32'hB100_0001, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_state1: got locked=%b expected 1", locked);
    end
    setData(1, 32'hB100_0002);
    req_last[1] = 1'b1;
    step();
    checkBeat("lock_beat2", 2'd1, 32'hB100_0002, 1'b1);
    checks++;
    if ({locked, pkt_cnt} !== {1'b0, 16'd6}) begin
      errors++;
      $display("FAIL lock_release: got locked=%b pkt_cnt=%0d expected 0 6", locked, pkt_cnt);
    end
    req_valid = 4'b0100;
    step();
    checkBeat("lock_waiter", 2'd2, 32'hC200_0000, 1'b1);
    checks++;
    if (pkt_cnt !== 16'd7) begin
      errors++;
      $display("FAIL lock_pkt_cnt: got %0d expected 7", pkt_cnt);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0101;
    req_last  = 4'hF;
    setData(0, 32'hDEADBEEF);
    setData(2, 32'h2222_2222);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first_ready: got %b expected 0001", req_ready);
    end
    step();
    checkBeat("bp_load", 2'd0, 32'hDEADBEEF, 1'b1);
    tok_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_ready_low: got %b expected 0000", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checkBeat("bp_hold", 2'd0, 32'hDEADBEEF, 1'b1);
      checks++;
      if ({req_ready, pkt_cnt} !== {4'b0000, 16'd8}) begin
        errors++;
        $display("FAIL bp_stall: got ready=%b pkt_cnt=%0d expected 0000 8", req_ready, pkt_cnt);
      end
    end
    tok_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_resume_ready: got %b expected 0100", req_ready);
    end
    step();
    checkBeat("bp_resume", 2'd2, 32'h2222_2222, 1'b1);
    checks++;
    if (pkt_cnt !== 16'd9) begin
      errors++;
      $display("FAIL bp_pkt_cnt: got %0d expected 9", pkt_cnt);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_wrap();
    // 65524 single-beat grants from pointer 3 bring the counter to 0xFFFD
    // and leave the pointer at 3, with the last beat from requester 2.
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) setData(i, 32'h3000 + i);
    repeat (65524) @(posedge clk);
    @(negedge clk);
    checkBeat("wrap_bulk_last", 2'd2, 32'h3002, 1'b1);
    checks++;
    if (pkt_cnt !== 16'hFFFD) begin
      errors++;
      $display("FAIL wrap_bulk_cnt: got %h expected fffd", pkt_cnt);
    end
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_req3_ready: got %b expected 1000", req_ready);
    end
    step();
    checkBeat("wrap_req3", 2'd3, 32'h3003, 1'b1);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_ptr_zero: got ready=%b expected 0001", req_ready);
    end
    step();
    checkBeat("wrap_req0", 2'd0, 32'h3000, 1'b1);
    checks++;
    if (pkt_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_cnt_max: got %h expected ffff", pkt_cnt);
    end
    step();
    checkBeat("wrap_after", 2'd3, 32'h3003, 1'b1);
    checks++;
    if (pkt_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_cnt_rollover: got %h expected 0000", pkt_cnt);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid_packet();
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    setData(1, 32'h1111_1111);
    step();
    checkBeat("mid_first_beat", 2'd1, 32'h1111_1111, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL mid_locked: got %b expected 1", locked);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({locked, tok_valid, req_ready, pkt_cnt} !== {1'b0, 1'b0, 4'b0000, 16'h0000}) begin
      errors++;
      $display("FAIL mid_async_reset: got locked=%b tok_valid=%b ready=%b pkt_cnt=%h expected 0 0 0000 0000",
               locked, tok_valid, req_ready, pkt_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    setData(0, 32'h0000_0055);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_restart_ready: got %b expected 0001", req_ready);
    end
    step();
    checkBeat("mid_restart_beat", 2'd0, 32'h0000_0055, 1'b1);
    checks++;
    if ({locked, pkt_cnt} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL mid_restart_state: got locked=%b pkt_cnt=%0d expected 0 1", locked, pkt_cnt);
    end
    req_valid = '0;
  endtask

  initial begin
    req_data = '0;
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_wrap();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
